// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared encodings for the pipeline run/stall controller.
package hazard_stall_ctrl_pkg;

    // Run-state encoding, also exported on the run_state port.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_DONE = 2'b11
    } run_state_e;

    // Debug command encodings from the UART command decoder.
    localparam logic [1:0] CMD_NOP  = 2'b00;
    localparam logic [1:0] CMD_RUN  = 2'b01;
    localparam logic [1:0] CMD_STEP = 2'b10;
    localparam logic [1:0] CMD_HALT = 2'b11;

endpackage : hazard_stall_ctrl_pkg

// File: rtl/hazard_stall_ctrl_load_use_detect.sv
// Load-use hazard compare: the load in EX writes a register that the
// instruction in ID reads. Register 0 is hard-wired and never hazards.
// Gating with the global enable is done by the parent.
module hazard_stall_ctrl_load_use_detect #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  i_mem_read,
    input  logic [REG_ADDR_W-1:0] i_ex_rt,
    input  logic [REG_ADDR_W-1:0] i_id_rs,
    input  logic [REG_ADDR_W-1:0] i_id_rt,
    output logic                  o_hazard_raw
);

    logic w_rt_nonzero;
    logic w_src_match;

    // Pure combinational compare of the EX load destination against both ID sources.
    always_comb begin
        w_rt_nonzero = (i_ex_rt != {REG_ADDR_W{1'b0}});
        w_src_match  = (i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt);
        o_hazard_raw = i_mem_read & w_rt_nonzero & w_src_match;
    end

endmodule : hazard_stall_ctrl_load_use_detect

// File: rtl/hazard_stall_ctrl.sv
// Pipeline run/step controller and load-use stall generator.
// enable is decoded from the registered run state only, so a debug command
// never reaches the latch enables combinationally. The stall triple is
// combinational (same cycle) because the stall must land before the edge.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_valid,
    input  logic [1:0]            cmd,
    input  logic                  halt_instr,
    input  logic                  ID_EX_mem_read,
    input  logic [REG_ADDR_W-1:0] ID_EX_rt,
    input  logic [REG_ADDR_W-1:0] IF_ID_rs,
    input  logic [REG_ADDR_W-1:0] IF_ID_rt,
    output logic                  enable,
    output logic                  PC_write,
    output logic                  IF_ID_write,
    output logic                  ID_EX_write,
    output logic                  step_done,
    output logic [1:0]            run_state,
    output logic [CNT_W-1:0]      cycle_count,
    output logic [CNT_W-1:0]      stall_count
);

    run_state_e       r_state;
    run_state_e       w_next_state;
    logic             r_step_done;
    logic [CNT_W-1:0] r_cycle_count;
    logic [CNT_W-1:0] r_stall_count;
    logic             w_enable;
    logic             w_hazard_raw;
    logic             w_hazard;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] res;
        if (&v) begin
            res = v;
        end else begin
            res = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    hazard_stall_ctrl_load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detect (
        .i_mem_read   (ID_EX_mem_read),
        .i_ex_rt      (ID_EX_rt),
        .i_id_rs      (IF_ID_rs),
        .i_id_rt      (IF_ID_rt),
        .o_hazard_raw (w_hazard_raw)
    );

    // Run-state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; halt_instr takes priority over a HALT command in RUN.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid && (cmd == CMD_RUN)) begin
                    w_next_state = ST_RUN;
                end else if (cmd_valid && (cmd == CMD_STEP)) begin
                    w_next_state = ST_STEP;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (halt_instr) begin
                    w_next_state = ST_DONE;
                end else if (cmd_valid && (cmd == CMD_HALT)) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_STEP: begin
                if (halt_instr) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_DONE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Enable decode from registered state and hazard gating.
    always_comb begin
        w_enable = (r_state == ST_RUN) || (r_state == ST_STEP);
        w_hazard = w_enable & w_hazard_raw;
    end

    // step_done pulses for the cycle following the single STEP cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_step_done <= 1'b0;
        end else begin
            r_step_done <= (r_state == ST_STEP);
        end
    end

    // Executed-cycle and stall-cycle counters, both saturating.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cycle_count <= {CNT_W{1'b0}};
            r_stall_count <= {CNT_W{1'b0}};
        end else begin
            if (w_enable) begin
                r_cycle_count <= sat_inc(r_cycle_count);
            end else begin
                r_cycle_count <= r_cycle_count;
            end
            if (w_hazard) begin
                r_stall_count <= sat_inc(r_stall_count);
            end else begin
                r_stall_count <= r_stall_count;
            end
        end
    end

    assign enable      = w_enable;
    assign PC_write    = ~w_hazard;
    assign IF_ID_write = ~w_hazard;
    assign ID_EX_write = ~w_hazard;
    assign step_done   = r_step_done;
    assign run_state   = r_state;
    assign cycle_count = r_cycle_count;
    assign stall_count = r_stall_count;

endmodule : hazard_stall_ctrl

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: a 32-bit counter instance for the
// functional sequence and a 4-bit counter instance for saturation/reset.
module tb_hazard_stall_ctrl;

    logic        clock;
    logic        reset;
    logic        cmd_valid;
    logic [1:0]  cmd;
    logic        halt_instr;
    logic        mem_read;
    logic [4:0]  ex_rt;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        enable;
    logic        pc_w;
    logic        ifid_w;
    logic        idex_w;
    logic        step_done;
    logic [1:0]  run_state;
    logic [31:0] cyc;
    logic [31:0] stl;

    logic        rst4;
    logic        cv4;
    logic [1:0]  cmd4;
    logic        en4;
    logic        pcw4;
    logic        ifw4;
    logic        idw4;
    logic        sd4;
    logic [1:0]  rs4;
    logic [3:0]  cyc4;
    logic [3:0]  stl4;

    int errors = 0;
    int checks = 0;

    hazard_stall_ctrl #(.CNT_W(32), .REG_ADDR_W(5)) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd),
        .halt_instr(halt_instr), .ID_EX_mem_read(mem_read), .ID_EX_rt(ex_rt),
        .IF_ID_rs(id_rs), .IF_ID_rt(id_rt), .enable(enable), .PC_write(pc_w),
        .IF_ID_write(ifid_w), .ID_EX_write(idex_w), .step_done(step_done),
        .run_state(run_state), .cycle_count(cyc), .stall_count(stl)
    );

    // Small-counter instance: load-use hazard permanently present (rt=3 vs rs=3).
    hazard_stall_ctrl #(.CNT_W(4), .REG_ADDR_W(5)) dut4 (
        .clock(clock), .reset(rst4), .cmd_valid(cv4), .cmd(cmd4),
        .halt_instr(1'b0), .ID_EX_mem_read(1'b1), .ID_EX_rt(5'd3),
        .IF_ID_rs(5'd3), .IF_ID_rt(5'd0), .enable(en4), .PC_write(pcw4),
        .IF_ID_write(ifw4), .ID_EX_write(idw4), .step_done(sd4),
        .run_state(rs4), .cycle_count(cyc4), .stall_count(stl4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step_clk();
        @(posedge clock);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr3(input string tag, input logic exp);
        chk({tag, "_pc"}, {31'd0, pc_w}, {31'd0, exp});
        chk({tag, "_ifid"}, {31'd0, ifid_w}, {31'd0, exp});
        chk({tag, "_idex"}, {31'd0, idex_w}, {31'd0, exp});
    endtask

    task automatic send(input logic [1:0] c);
        cmd_valid = 1'b1;
        cmd = c;
        step_clk();
        cmd_valid = 1'b0;
        cmd = 2'b00;
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd = 2'b00; halt_instr = 1'b0;
        mem_read = 1'b0; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        rst4 = 1'b1; cv4 = 1'b0; cmd4 = 2'b00;
        step_clk();
        step_clk();
        reset = 1'b0;

        // 1: idle after reset, no commands for 20 cycles
        repeat (20) step_clk();
        chk("t1_enable", {31'd0, enable}, 32'd0);
        chk("t1_state", {30'd0, run_state}, 32'd0);
        chk("t1_cyc", cyc, 32'd0);
        chk("t1_stl", stl, 32'd0);
        chk("t1_sd", {31'd0, step_done}, 32'd0);
        mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        #1;
        wr3("t1_idle_gated", 1'b1);
        mem_read = 1'b0; ex_rt = 5'd0; id_rs = 5'd0;

        // 2: single STEP
        send(2'b10);
        chk("t2_enable_on", {31'd0, enable}, 32'd1);
        chk("t2_state_step", {30'd0, run_state}, 32'd2);
        step_clk();
        chk("t2_enable_off", {31'd0, enable}, 32'd0);
        chk("t2_sd_pulse", {31'd0, step_done}, 32'd1);
        chk("t2_cyc", cyc, 32'd1);
        chk("t2_state_idle", {30'd0, run_state}, 32'd0);
        step_clk();
        chk("t2_sd_clear", {31'd0, step_done}, 32'd0);

        // 3: load-use stall in RUN
        send(2'b01);
        chk("t3_state_run", {30'd0, run_state}, 32'd1);
        mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_rt = 5'd1;
        #1;
        wr3("t3_rs_hazard", 1'b0);
        step_clk();
        chk("t3_stl1", stl, 32'd1);
        chk("t3_cyc2", cyc, 32'd2);
        ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        #1;
        wr3("t3_r0_nostall", 1'b1);
        step_clk();
        chk("t3_stl_r0", stl, 32'd1);
        ex_rt = 5'd7; id_rs = 5'd3; id_rt = 5'd7;
        #1;
        wr3("t3_rt_hazard", 1'b0);
        step_clk();
        chk("t3_stl2", stl, 32'd2);
        chk("t3_cyc4", cyc, 32'd4);
        mem_read = 1'b0;
        #1;
        wr3("t3_noload", 1'b1);
        mem_read = 1'b1; ex_rt = 5'd7; id_rs = 5'd6; id_rt = 5'd8;
        #1;
        wr3("t3_nomatch", 1'b1);
        mem_read = 1'b0; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;

        // 4: RUN 10 cycles, HALT, resume (async reset mid-RUN first)
        #1 reset = 1'b1;
        #1;
        chk("t4_rst_enable", {31'd0, enable}, 32'd0);
        chk("t4_rst_cyc", cyc, 32'd0);
        reset = 1'b0;
        step_clk();
        send(2'b01);
        repeat (9) step_clk();
        chk("t4_cyc9", cyc, 32'd9);
        send(2'b11);
        chk("t4_state_idle", {30'd0, run_state}, 32'd0);
        chk("t4_enable_off", {31'd0, enable}, 32'd0);
        chk("t4_cyc10", cyc, 32'd10);
        repeat (3) step_clk();
        chk("t4_cyc_hold", cyc, 32'd10);
        send(2'b01);
        chk("t4_cyc_rerun", cyc, 32'd10);
        step_clk();
        chk("t4_cyc11", cyc, 32'd11);
        send(2'b10);
        chk("t4_step_ignored", {30'd0, run_state}, 32'd1);
        send(2'b00);
        chk("t4_nop_ignored", {30'd0, run_state}, 32'd1);
        cmd = 2'b11;
        step_clk();
        cmd = 2'b00;
        chk("t4_novalid_ignored", {30'd0, run_state}, 32'd1);
        chk("t4_cyc14", cyc, 32'd14);

        // 5: halt_instr and HALT command together -> DONE, sticky
        halt_instr = 1'b1;
        send(2'b11);
        halt_instr = 1'b0;
        chk("t5_state_done", {30'd0, run_state}, 32'd3);
        chk("t5_enable_off", {31'd0, enable}, 32'd0);
        send(2'b01);
        send(2'b10);
        step_clk();
        chk("t5_done_sticky", {30'd0, run_state}, 32'd3);
        chk("t5_enable_stays", {31'd0, enable}, 32'd0);
        chk("t5_cyc_frozen", cyc, 32'd15);

        // 7: STEP with hazard, then STEP ending on halt_instr
        reset = 1'b1;
        #1;
        chk("t7_rst_state", {30'd0, run_state}, 32'd0);
        reset = 1'b0;
        step_clk();
        send(2'b10);
        mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
        #1;
        wr3("t7_step_hazard", 1'b0);
        step_clk();
        chk("t7_sd", {31'd0, step_done}, 32'd1);
        chk("t7_stl", stl, 32'd1);
        chk("t7_cyc", cyc, 32'd1);
        wr3("t7_after_gated", 1'b1);
        mem_read = 1'b0; ex_rt = 5'd0; id_rs = 5'd0;
        send(2'b10);
        halt_instr = 1'b1;
        step_clk();
        halt_instr = 1'b0;
        chk("t7_step_done_state", {30'd0, run_state}, 32'd3);
        chk("t7_sd_halt", {31'd0, step_done}, 32'd1);
        chk("t7_cyc2", cyc, 32'd2);

        // 6: saturation on the 4-bit instance, async reset mid-RUN and mid-STEP
        rst4 = 1'b0;
        step_clk();
        cv4 = 1'b1; cmd4 = 2'b01;
        step_clk();
        cv4 = 1'b0; cmd4 = 2'b00;
        chk("t6_pc_stall", {31'd0, pcw4}, 32'd0);
        repeat (20) step_clk();
        chk("t6_cyc_sat", {28'd0, cyc4}, 32'hF);
        chk("t6_stl_sat", {28'd0, stl4}, 32'hF);
        chk("t6_enable_run", {31'd0, en4}, 32'd1);
        rst4 = 1'b1;
        #1;
        chk("t6_rst_enable", {31'd0, en4}, 32'd0);
        chk("t6_rst_cyc", {28'd0, cyc4}, 32'd0);
        chk("t6_rst_stl", {28'd0, stl4}, 32'd0);
        chk("t6_rst_pcw", {31'd0, pcw4}, 32'd1);
        rst4 = 1'b0;
        step_clk();
        cv4 = 1'b1; cmd4 = 2'b10;
        step_clk();
        cv4 = 1'b0; cmd4 = 2'b00;
        chk("t6_step_on", {31'd0, en4}, 32'd1);
        rst4 = 1'b1;
        #1;
        rst4 = 1'b0;
        step_clk();
        chk("t6_no_sd", {31'd0, sd4}, 32'd0);
        chk("t6_state_idle", {30'd0, rs4}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_hazard_stall_ctrl
